// File: rtl/bitty_sequencer_if.sv
// bitty_sequencer_if: fetch handshake plus datapath control bundle for bitty_sequencer.
// master = fetch/testbench side, slave = the sequencer.
interface bitty_sequencer_if #(
    parameter int INSTR_W  = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
);
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int IMM_W  = INSTR_W - REG_AW - SEL_W - 3;

    logic                run;
    logic [INSTR_W-1:0]  instruction;
    logic                ready;
    logic [REG_AW-1:0]   mux_sel;
    logic                imm_sel;
    logic [IMM_W-1:0]    imm_out;
    logic [SEL_W-1:0]    sel;
    logic                mode;
    logic                en_s;
    logic                en_c;
    logic [NUM_REGS-1:0] en_reg;
    logic                done;
    logic                err;

    modport master (
        output run, instruction,
        input  ready, mux_sel, imm_sel, imm_out, sel, mode, en_s, en_c, en_reg, done, err
    );

    modport slave (
        input  run, instruction,
        output ready, mux_sel, imm_sel, imm_out, sel, mode, en_s, en_c, en_reg, done, err
    );
endinterface

// File: rtl/bitty_sequencer.sv
// bitty_sequencer: issues one instruction as load-S, load-C (register or immediate), writeback.
// Outputs are decoded from the state and the latched instruction only.
module bitty_sequencer #(
    parameter int INSTR_W  = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
) (
    input logic clk,
    input logic reset,
    bitty_sequencer_if.slave bus
);
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int IMM_W  = INSTR_W - REG_AW - SEL_W - 3;

    typedef enum logic [2:0] {IDLE, LD_S, LD_C, WB, ERR} state_t;

    state_t             state, state_next;
    logic [INSTR_W-1:0] instr_q;
    logic [SEL_W-1:0]   sel_q;
    logic               mode_q;
    logic               capture;
    logic [REG_AW-1:0]  rx, ry;

    assign rx      = instr_q[INSTR_W-1 -: REG_AW];
    assign ry      = instr_q[INSTR_W-REG_AW-1 -: REG_AW];
    assign capture = bus.run && (state == IDLE || state == WB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            instr_q <= '0;
            sel_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (capture)
                instr_q <= bus.instruction;
            // ALU controls become valid on entry to LD_C and hold afterwards
            if (state == LD_S) begin
                sel_q  <= instr_q[SEL_W+2:3];
                mode_q <= instr_q[2];
            end
        end
    end

    always_comb begin
        state_next  = (state == LD_S) ? LD_C :
                      (state == LD_C) ? WB :
                      capture         ? (bus.instruction[1] ? ERR : LD_S) : IDLE;
        bus.ready   = (state == IDLE) || (state == WB);
        bus.mux_sel = (state == LD_S)                ? rx :
                      (state == LD_C && !instr_q[0]) ? ry : '0;
        bus.imm_sel = (state == LD_C) && instr_q[0];
        bus.en_s    = (state == LD_S);
        bus.en_c    = (state == LD_C);
        bus.en_reg  = (state == WB) ? (NUM_REGS'(1) << rx) : '0;
        bus.done    = (state == WB);
        bus.err     = (state == ERR);
    end

    assign bus.imm_out = instr_q[INSTR_W-REG_AW-1:SEL_W+3];
    assign bus.sel     = sel_q;
    assign bus.mode    = mode_q;
endmodule
